imem_loader: RTL and testbench

- Byte-stream program loader. It writes the instruction memory that the single-cycle core fetches from, and is the writer side of the instruction-fetch read path.
- It receives a framed program image over a valid/ready byte interface and assembles 32-bit words. It then writes those words into consecutive word addresses starting at 0 and releases the core via cpu_run.
- It sits between a host/UART front end and the instruction memory write port. The core is held off (cpu_run low) until a load completes cleanly.

---
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Assembles a framed big-endian byte stream into 32-bit words written to imem from address 0; strobe follows the 4th byte's accept edge by one cycle.
// in_ready drops in DONE/ERR and while load_restart is high; the host may stall between any bytes indefinitely.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              load_restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int MAX_WORDS = 2 ** ADDR_W;

    typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;
    state_t state, state_nxt;

    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic [23:0] partial;
    logic        accept;
    logic [16:0] hdr_len;
    logic        last_word;

    assign in_ready  = (state != DONE) && (state != ERR) && !load_restart;
    assign accept    = in_valid && in_ready;
    assign hdr_len   = {1'b0, len_hi, in_data};
    // words_loaded doubles as the index of the word currently being assembled
    assign last_word = (17'(words_loaded) + 17'd1) == {1'b0, len};
    assign load_done = (state == DONE);
    assign load_err  = (state == ERR);
    assign cpu_run   = load_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (load_restart) begin
            state_nxt = HDR0;
        end else if (accept) begin
            case (state)
                HDR0: state_nxt = HDR1;
                HDR1: begin
                    if (hdr_len > 17'(MAX_WORDS)) begin
                        state_nxt = ERR;
                    end else if (hdr_len == 17'd0) begin
                        state_nxt = CSUM;
                    end else begin
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (byte_idx == 2'd3 && last_word) begin
                        state_nxt = CSUM;
                    end
                end
                CSUM:    state_nxt = (in_data == csum) ? DONE : ERR;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            len_hi       <= '0;
            len          <= '0;
            csum         <= '0;
            byte_idx     <= '0;
            partial      <= '0;
        end else begin
            imem_we <= 1'b0;
            if (load_restart) begin
                words_loaded <= '0;
                len_hi       <= '0;
                len          <= '0;
                csum         <= '0;
                byte_idx     <= '0;
                partial      <= '0;
            end else if (accept) begin
                case (state)
                    HDR0: begin
                        len_hi <= in_data;
                        csum   <= csum ^ in_data;
                    end
                    HDR1: begin
                        len  <= {len_hi, in_data};
                        csum <= csum ^ in_data;
                    end
                    DATA: begin
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= words_loaded[ADDR_W-1:0];
                            imem_wdata   <= {partial, in_data};
                            words_loaded <= words_loaded + 1'b1;
                        end else begin
                            partial <= {partial[15:0], in_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed frame table, hand-written latency/restart/reset sequences,
// then random frames with random host stalls checked against a frame-level reference model.
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              load_restart = 1'b0;
    logic              in_ready, imem_we, cpu_run, load_done, load_err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .load_restart(load_restart), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
        .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          passed = 0;
    int          gap_max = 0;
    logic [39:0] wr_q[$];
    logic [7:0]  frame_q[$];
    logic [31:0] exp_q[$];
    logic        exp_done, exp_err;
    int          exp_words, nsend;

    typedef struct {
        int           nb;
        logic [127:0] bytes;
        logic         done;
        logic         err;
        int           words;
        logic [31:0]  w0;
    } vec_t;
    vec_t tv[7];

    always @(negedge clk) if (imem_we) wr_q.push_back({imem_addr, imem_wdata});

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gaps;
        int t;
        gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (gaps) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("send_accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_list(input logic [127:0] bv, input int nb);
        for (int i = 0; i < nb; i++) send_byte(bv[8*(nb-1-i) +: 8]);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        in_valid     = 1'b0;
        load_restart = 1'b1;
        @(posedge clk);
        #1;
        load_restart = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame-level reference: decode the header, split the payload into words, XOR-check the trailer.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_q.delete();
        n = int'({frame_q[0], frame_q[1]});
        if (n > (1 << ADDR_W)) begin
            exp_err = 1'b1; exp_done = 1'b0; exp_words = 0; nsend = 2;
        end else begin
            x = 8'h00;
            for (int i = 0; i < frame_q.size() - 1; i++) x ^= frame_q[i];
            for (int w = 0; w < n; w++)
                exp_q.push_back({frame_q[2+4*w], frame_q[3+4*w], frame_q[4+4*w], frame_q[5+4*w]});
            exp_done  = (frame_q[frame_q.size()-1] == x);
            exp_err   = !exp_done;
            exp_words = n;
            nsend     = frame_q.size();
        end
    endtask

    task automatic build_random(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
        x = frame_q[0] ^ frame_q[1];
        if (n <= (1 << ADDR_W)) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                frame_q.push_back(b);
                x ^= b;
            end
            if (corrupt) x ^= 8'(1 << $urandom_range(0, 7));
            frame_q.push_back(x);
        end
    endtask

    task automatic run_frame(input string tag);
        logic [7:0] a;
        pulse_restart();
        wr_q.delete();
        model();
        for (int i = 0; i < nsend; i++) send_byte(frame_q[i]);
        idle(3);
        check({tag, "_done"}, load_done, exp_done);
        check({tag, "_err"}, load_err, exp_err);
        check({tag, "_run"}, cpu_run, exp_done);
        check({tag, "_words"}, words_loaded, exp_words);
        check({tag, "_ready"}, in_ready, 1'b0);
        check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            a = 8'(i);
            check($sformatf("%s_wr%0d", tag, i), wr_q[i], {a, exp_q[i]});
        end
    endtask

    initial begin
        logic [127:0] bv;
        logic [39:0]  last;
        int           n;
        int           kind;

        // Checksum of 00 02 20 08 00 05 01 09 50 20 is 0x57 (XOR of all ten bytes).
        tv[0] = '{11, 128'h0002_2008_0005_0109_5020_57, 1'b1, 1'b0, 2, 32'h2008_0005};
        tv[1] = '{11, 128'h0002_2008_0005_0109_5020_4A, 1'b0, 1'b1, 2, 32'h2008_0005};
        tv[2] = '{11, 128'h0002_2008_0005_0109_5020_57, 1'b1, 1'b0, 2, 32'h2008_0005};
        tv[3] = '{3, 128'h00_00_00, 1'b1, 1'b0, 0, 32'h0};
        tv[4] = '{3, 128'h00_00_01, 1'b0, 1'b1, 0, 32'h0};
        tv[5] = '{2, 128'h01_01, 1'b0, 1'b1, 0, 32'h0};
        tv[6] = '{7, 128'h00_01_DE_AD_BE_EF_23, 1'b1, 1'b0, 1, 32'hDEAD_BEEF};

        repeat (3) @(negedge clk);
        check("reset_outputs", {imem_we, imem_addr, imem_wdata, load_done, load_err, cpu_run, words_loaded}, 64'd0);
        check("reset_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            pulse_restart();
            wr_q.delete();
            bv = tv[k].bytes;
            send_list(bv, tv[k].nb);
            idle(2);
            check($sformatf("v%0d_done", k), load_done, tv[k].done);
            check($sformatf("v%0d_err", k), load_err, tv[k].err);
            check($sformatf("v%0d_run", k), cpu_run, tv[k].done);
            check($sformatf("v%0d_words", k), words_loaded, tv[k].words);
            check($sformatf("v%0d_ready", k), in_ready, 1'b0);
            check($sformatf("v%0d_nwrites", k), wr_q.size(), tv[k].words);
            if (tv[k].words > 0 && wr_q.size() > 0)
                check($sformatf("v%0d_wr0", k), wr_q[0], {8'h00, tv[k].w0});
        end

        // Write strobe timing: high for exactly the cycle after the 4th byte's edge.
        pulse_restart();
        wr_q.delete();
        send_list(128'h00_02_20_08_00, 5);
        send_byte(8'h05);
        check("lat_we_high", imem_we, 1'b1);
        check("lat_addr", imem_addr, 8'h00);
        check("lat_wdata", imem_wdata, 32'h2008_0005);
        check("lat_words", words_loaded, 1);
        @(posedge clk);
        #1;
        check("lat_we_low", imem_we, 1'b0);
        check("lat_wdata_held", imem_wdata, 32'h2008_0005);
        send_list(128'h01_09_50_20_57, 5);
        idle(2);
        check("lat_wr1", wr_q.size() > 1 ? wr_q[1] : 40'h0, {8'h01, 32'h0109_5020});
        check("lat_done", load_done, 1'b1);

        // Restart collides with the 4th byte of word 0.
        pulse_restart();
        wr_q.delete();
        send_list(128'h00_01_DE_AD_BE, 5);
        @(negedge clk);
        in_valid     = 1'b1;
        in_data      = 8'hEF;
        load_restart = 1'b1;
        #1;
        check("rst_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1;
        load_restart = 1'b0;
        in_valid     = 1'b0;
        check("rst_we", imem_we, 1'b0);
        check("rst_words", words_loaded, 0);
        idle(2);
        check("rst_nwrites", wr_q.size(), 0);
        check("rst_hdr0_ready", in_ready, 1'b1);
        send_list(128'h00_01_DE_AD_BE_EF_23, 7);
        idle(2);
        check("rst_reload_done", load_done, 1'b1);
        check("rst_reload_wr", wr_q.size() > 0 ? wr_q[0] : 40'h0, {8'h00, 32'hDEAD_BEEF});

        // Asynchronous reset between bytes of a data word, away from the clock edge.
        pulse_restart();
        wr_q.delete();
        send_list(128'h00_01_CA_FE, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_outputs", {imem_we, imem_addr, imem_wdata, load_done, load_err, cpu_run, words_loaded}, 64'd0);
        check("arst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        wr_q.delete();
        send_list(128'h00_01_12_34_56_78_09, 7);
        idle(2);
        check("arst_nwrites", wr_q.size(), 1);
        check("arst_wr", wr_q.size() > 0 ? wr_q[0] : 40'h0, {8'h00, 32'h1234_5678});
        check("arst_done", load_done, 1'b1);

        // Random frames with host stalls.
        gap_max = 3;
        for (int it = 0; it < 12; it++) begin
            kind = int'($urandom_range(0, 9));
            n = (kind == 0) ? int'($urandom_range(257, 65535)) : int'($urandom_range(0, 12));
            build_random(n, kind == 1);
            run_frame($sformatf("rnd%0d", it));
        end

        // Full-capacity image.
        gap_max = 0;
        build_random(1 << ADDR_W, 1'b0);
        run_frame("full");
        last = (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : 40'h0;
        check("full_last_addr", last[39:32], 8'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
